spike_order_detector: RTL
=========================

# spike_order_detector

Downstream consumer of the masked 4-channel spike stream; runs in the r_clk_tst domain. Detects one ordered spike sequence: ch0 → ch1 → ch2 → ch3, with every inter-spike gap inside a programmable cycle window. Each completed sequence produces a one-cycle detect pulse, the summed sequence latency and a running detection count. Each violation produces a one-cycle error pulse with a cause code. Feeds the level-2 classification logic.

## Interface
- p_gap_min, 16, minimum accepted gap in cycles, inclusive
- p_gap_max, 40, maximum accepted gap in cycles, inclusive; must be ≥ p_gap_min and < 2^p_cnt_w − 1
- p_cnt_w, 7, gap counter width
- r_clk_tst  in  1  clock, rising edge
- r_rst_n  in  1  reset; asynchronous, active-low
- i_enable  in  1  detector enable; synchronous, level
- i_spike  in  4  spike vector; each bit is a one-cycle pulse
- o_detect  out  1  one-cycle pulse when a full sequence is accepted
- o_error  out  1  one-cycle pulse on a sequence violation
- o_err_code  out  2  cause code: 1 = order, 2 = early, 3 = timeout; held until the next error
- o_gap_sum  out  p_cnt_w+2  sum of the three gaps of the last detected sequence; held
- o_det_count  out  8  count of detections; wraps 255 → 0
- o_busy  out  1  high whenever the state is not IDLE

## Operation
- Reset values: all outputs 0; state IDLE; gap counter 0; accumulator 0.
- States: IDLE, WAIT1, WAIT2, WAIT3. In WAITk the expected spike is the one-hot bit k.
- IDLE:
  - i_spike == 4'b0001 → WAIT1; counter cleared to 0; accumulator cleared.
  - Any other vector is ignored, multi-hot included.
- WAITk gap counter:
  - Increments by 1 every cycle with no acceptance; saturates at p_gap_max+1.
  - The sampled value is the number of cycles since the previous accepted spike.
- WAITk, evaluated in this priority order on each edge:
  - (a) i_spike == expected one-hot and p_gap_min ≤ cnt ≤ p_gap_max: accept. Accumulator += cnt; counter cleared. WAIT1→WAIT2, WAIT2→WAIT3. WAIT3 → IDLE, with o_detect pulse, o_gap_sum ← final sum, o_det_count+1.
  - (b) i_spike == expected one-hot and cnt < p_gap_min: error code 2.
  - (c) i_spike nonzero and not the expected one-hot (wrong bit or multi-hot): error code 1.
  - (d) i_spike == 0 and cnt == p_gap_max: error code 3 (timeout).
- Error: o_error pulse; o_err_code updated; state → IDLE.
  - Exception: if the offending vector is exactly 4'b0001, state → WAIT1 with counter and accumulator cleared (re-acquire in the same cycle).
- i_enable low:
  - Next state IDLE; counter and accumulator cleared.
  - o_detect and o_error forced 0.
  - Held outputs (o_err_code, o_gap_sum, o_det_count) are retained.
  - Dropping i_enable mid-sequence raises no error.
- Reset mid-sequence: immediate return to reset values; no pulse is emitted.

## Timing
- All outputs registered. Latency from spike sample edge to o_detect/o_error is 1 cycle; both pulses are exactly 1 cycle wide.
- o_detect and o_error are mutually exclusive in every cycle.
- o_busy rises the cycle after the ch0 acceptance edge. It falls the cycle after the detect, error or disable edge, except that it stays high on a re-acquire.
- o_gap_sum and o_det_count update in the same cycle o_detect is high.
- Maximum sequence length is 3·p_gap_max cycles. o_gap_sum width p_cnt_w+2 cannot overflow.

## Structure
- Shared package spike_pkg holds:
  - state enum (IDLE = 0, WAIT1, WAIT2, WAIT3)
  - error codes (ERR_ORDER = 1, ERR_EARLY = 2, ERR_TIMEOUT = 3)
  - channel count constant P_NCH = 4
- One sub-module, gap_counter: saturating up-counter with synchronous clear and parameterised width and saturation value. Instanced once.
- Remainder is a single FSM plus output registers.

## Test plan
- Valid sequence: ch0, then ch1, ch2, ch3 at gaps 32/32/32 → one o_detect pulse; o_gap_sum = 96; o_det_count = 1; o_error never high.
- Early spike: ch0, then ch1 at gap 10 → o_error with o_err_code = 2; o_busy low the next cycle; no detect.
- Order violation: ch0, then ch2 at gap 20 → o_err_code = 1. Separately, ch0 then a multi-hot 4'b0110 at gap 20 → o_err_code = 1.
- Timeout and re-acquire:
  - ch0, then silence → o_error with code 3 exactly when the counter reaches 40.
  - ch0, then ch0 again at gap 20 → code 1, and the bench confirms re-acquire by accepting ch1, ch2, ch3 at gap 20 each from the second ch0 → detect with o_gap_sum = 60.
- Boundary gaps: sequences with all gaps = 16, then all gaps = 40 → both detect, with o_gap_sum 48 and 120; a gap of 41 yields timeout instead.
- Disable and reset: drop i_enable after ch2 is accepted → IDLE, no error, o_det_count unchanged. 256 valid sequences → o_det_count wraps to 0. Assert r_rst_n mid-WAIT2 → all outputs 0 immediately.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared definitions for the spike order detector.
//   state_e      : detector FSM state encoding
//   ERR_*        : error cause codes reported on o_err_code
//   P_NCH        : number of spike channels
//   expected_spike() : one-hot channel vector expected in a given WAIT state
package spike_pkg;

  localparam int P_NCH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    WAIT3 = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ORDER   = 2'd1;
  localparam logic [1:0] ERR_EARLY   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // WAITk waits for channel k, so the state value doubles as the channel index.
  function automatic logic [P_NCH-1:0] expected_spike(input state_e s);
    logic [P_NCH-1:0] v;
    v = '0;
    v[int'(s)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/spike_order_detector_gap_counter.sv
// gap_counter: saturating up-counter with synchronous clear.
//   r_clk_tst : clock, rising edge
//   r_rst_n   : asynchronous active-low reset (count -> 0)
//   i_clr     : synchronous clear; has priority over counting
//   o_count   : current count, stops at p_sat
module gap_counter #(
  parameter int p_width = 7,
  parameter int p_sat   = 41
) (
  input  logic               r_clk_tst,
  input  logic               r_rst_n,
  input  logic               i_clr,
  output logic [p_width-1:0] o_count
);

  localparam logic [p_width-1:0] SAT = p_width'(p_sat);

  logic [p_width-1:0] count_q;
  logic [p_width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (count_q < SAT) begin
      count_d = count_q + p_width'(1);
    end
  end

  always_ff @(posedge r_clk_tst or negedge r_rst_n) begin
    if (!r_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/spike_order_detector.sv
// spike_order_detector: detects the ordered spike sequence ch0 -> ch1 -> ch2 -> ch3
// with every inter-spike gap inside [p_gap_min, p_gap_max] cycles.
//   r_clk_tst, r_rst_n : clock / asynchronous active-low reset
//   i_enable           : level enable; low forces IDLE without raising an error
//   i_spike            : 4-bit spike vector (one-cycle pulses)
//   o_detect           : one-cycle pulse on an accepted full sequence
//   o_error            : one-cycle pulse on a violation
//   o_err_code         : cause of the last error (1 order, 2 early, 3 timeout), held
//   o_gap_sum          : sum of the three gaps of the last detected sequence, held
//   o_det_count        : wrapping 8-bit detection count
//   o_busy             : high whenever a sequence is in progress
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a lone ch0 spike to start a sequence
// WAIT1 | ch0 accepted, expecting ch1 inside the gap window
// WAIT2 | ch1 accepted, expecting ch2 inside the gap window
// WAIT3 | ch2 accepted, expecting ch3; acceptance completes a detect
module spike_order_detector
  import spike_pkg::*;
#(
  parameter int p_gap_min = 16,
  parameter int p_gap_max = 40,
  parameter int p_cnt_w   = 7
) (
  input  logic               r_clk_tst,
  input  logic               r_rst_n,
  input  logic               i_enable,
  input  logic [P_NCH-1:0]   i_spike,
  output logic               o_detect,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [p_cnt_w+1:0] o_gap_sum,
  output logic [7:0]         o_det_count,
  output logic               o_busy
);

  localparam int W = p_cnt_w;
  localparam logic [W:0]       GAP_MIN = (W+1)'(p_gap_min);
  localparam logic [W:0]       GAP_MAX = (W+1)'(p_gap_max);
  localparam logic [P_NCH-1:0] CH0     = P_NCH'(1);

  logic [W-1:0] cnt_q;
  logic         cnt_clr;

  gap_counter #(
    .p_width (W),
    .p_sat   (p_gap_max + 1)
  ) u_gap_counter (
    .r_clk_tst (r_clk_tst),
    .r_rst_n   (r_rst_n),
    .i_clr     (cnt_clr),
    .o_count   (cnt_q)
  );

  state_e       state_q,     state_d;
  logic [W+1:0] acc_q,       acc_d;
  logic         detect_q,    detect_d;
  logic         error_q,     error_d;
  logic [1:0]   err_code_q,  err_code_d;
  logic [W+1:0] gap_sum_q,   gap_sum_d;
  logic [7:0]   det_count_q, det_count_d;

  // The counter is cleared on the acceptance edge, so it reads 0 one cycle
  // later; adding one gives the number of cycles since the accepted spike.
  logic [W:0]       gap_now;
  logic [W+1:0]     acc_sum;
  logic [P_NCH-1:0] exp_spike;
  logic             in_window;

  assign gap_now   = {1'b0, cnt_q} + (W+1)'(1);
  assign acc_sum   = acc_q + {1'b0, gap_now};
  assign exp_spike = expected_spike(state_q);
  assign in_window = (gap_now >= GAP_MIN) && (gap_now <= GAP_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    detect_d    = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    gap_sum_d   = gap_sum_q;
    det_count_d = det_count_q;
    cnt_clr     = 1'b0;

    if (!i_enable) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_clr = 1'b1;
    end else if (state_q == IDLE) begin
      cnt_clr = 1'b1;
      if (i_spike == CH0) begin
        state_d = WAIT1;
        acc_d   = '0;
      end
    end else begin
      if ((i_spike == exp_spike) && in_window) begin
        cnt_clr = 1'b1;
        acc_d   = acc_sum;
        case (state_q)
          WAIT1:   state_d = WAIT2;
          WAIT2:   state_d = WAIT3;
          default: begin
            state_d     = IDLE;
            detect_d    = 1'b1;
            gap_sum_d   = acc_sum;
            det_count_d = det_count_q + 8'd1;
          end
        endcase
      end else if (i_spike == exp_spike) begin
        error_d    = 1'b1;
        err_code_d = ERR_EARLY;
      end else if (i_spike != '0) begin
        error_d    = 1'b1;
        err_code_d = ERR_ORDER;
      end else if (gap_now == GAP_MAX) begin
        error_d    = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end

      // A lone ch0 that caused the error also starts a fresh sequence.
      if (error_d) begin
        cnt_clr = 1'b1;
        acc_d   = '0;
        state_d = (i_spike == CH0) ? WAIT1 : IDLE;
      end
    end
  end

  always_ff @(posedge r_clk_tst or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      detect_q    <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      gap_sum_q   <= '0;
      det_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      detect_q    <= detect_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      gap_sum_q   <= gap_sum_d;
      det_count_q <= det_count_d;
    end
  end

  assign o_detect    = detect_q;
  assign o_error     = error_q;
  assign o_err_code  = err_code_q;
  assign o_gap_sum   = gap_sum_q;
  assign o_det_count = det_count_q;
  assign o_busy      = (state_q != IDLE);

endmodule
